// File: rtl/processor_pipe3_if.sv
// processor_pipe3_if: bus between the three-stage core and its environment
// (instruction ROM, data memory, retirement counter).
//
// Handshake: the data memory has no request/grant pair. While the core's
// W stage holds a valid load or store it presents data_addr/data_out/data_w
// and keeps them stable; the access completes on the rising edge at which
// mem_ready=1, and data_in is only meaningful in that cycle.
//
// Signals:
//   insn      ROM -> core  instruction at insn_addr (combinational ROM)
//   insn_addr core -> ROM  current PC
//   data_w    core -> mem  write strobe
//   data_out  core -> mem  store data
//   data_in   mem -> core  load data, valid when mem_ready=1
//   data_addr core -> mem  data address
//   mem_ready mem -> core  access completes this cycle
//   retired   core -> env  retired-instruction count, wraps
interface processor_pipe3_if #(
    parameter int XLEN = 32
);
    logic [31:0]     insn;
    logic [XLEN-1:0] insn_addr;
    logic            data_w;
    logic [XLEN-1:0] data_out;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] data_addr;
    logic            mem_ready;
    logic [31:0]     retired;

    modport master (
        input  insn, data_in, mem_ready,
        output insn_addr, data_w, data_out, data_addr, retired
    );

    modport slave (
        output insn, data_in, mem_ready,
        input  insn_addr, data_w, data_out, data_addr, retired
    );
endinterface

// File: rtl/processor_pipe3.sv
// processor_pipe3: three-stage in-order core (Decode, Execute,
// Memory/Writeback) with an internal register file.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (wins over a memory stall)
//   bus  processor_pipe3_if.master: instruction fetch, data memory and
//        retirement counter
//
// Instruction fields, LSB up: src1, src2, dst (RA bits each), imm (IMM_W,
// sign-extended), then m_w, r_w, op, r_src, b. Bits above are ignored.
// ALU: op=0 -> A+B+imm, op=1 -> A-B+imm. Stores write operand B to address
// alu_result; loads (r_src) write data_in to dst. Taken branches (b) go to
// E.pc + alu_result and squash the two younger wrong-path instructions.
// The whole pipe freezes while W holds a memory access and mem_ready=0.
module processor_pipe3 #(
    parameter int XLEN    = 32,
    parameter int RA      = 5,
    parameter int IMM_W   = 5,
    parameter int R0_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst,
    processor_pipe3_if.master  bus
);
    // Parameters must satisfy 3*RA+IMM_W+5 <= 32.
    localparam int NREGS = 2 ** RA;
    localparam int F     = 3 * RA + IMM_W;
    localparam int IW    = F + 5;

    // Architectural / pipeline state
    logic [XLEN-1:0] pc;
    logic [31:0]     retired_q;
    logic [XLEN-1:0] regs [NREGS];

    logic            d_valid;
    logic [IW-1:0]   d_insn;
    logic [XLEN-1:0] d_pc;

    logic            e_valid;
    logic [IW-1:0]   e_insn;
    logic [XLEN-1:0] e_pc;

    logic            w_valid;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_store;
    logic [RA-1:0]   w_dst;
    logic            w_mw;
    logic            w_rw;
    logic            w_rsrc;

    // E-stage decode
    logic [RA-1:0]    e_src1, e_src2, e_dst;
    logic [IMM_W-1:0] e_imm;
    logic             e_mw, e_rw, e_op, e_rsrc, e_b;
    logic [XLEN-1:0]  imm_ext;

    assign e_src1  = e_insn[RA-1:0];
    assign e_src2  = e_insn[2*RA-1:RA];
    assign e_dst   = e_insn[3*RA-1:2*RA];
    assign e_imm   = e_insn[F-1:3*RA];
    assign e_mw    = e_insn[F];
    assign e_rw    = e_insn[F+1];
    assign e_op    = e_insn[F+2];
    assign e_rsrc  = e_insn[F+3];
    assign e_b     = e_insn[F+4];
    assign imm_ext = {{(XLEN-IMM_W){e_imm[IMM_W-1]}}, e_imm};

    // Writeback value and enable. With R0_ZERO, a write to R0 is dropped and
    // must not be forwarded either, so both share this single enable.
    logic [XLEN-1:0] wb_val;
    logic            wb_en;
    logic            stall;

    assign wb_val = w_rsrc ? bus.data_in : w_alu;
    assign wb_en  = w_valid & w_rw & !((R0_ZERO != 0) && (w_dst == '0));
    assign stall  = w_valid & (w_mw | w_rsrc) & !bus.mem_ready;

    // Register read in E with W->E bypass
    logic [XLEN-1:0] rf_a, rf_b, op_a, op_b, alu;
    logic            taken;

    assign rf_a = ((R0_ZERO != 0) && (e_src1 == '0)) ? '0 : regs[e_src1];
    assign rf_b = ((R0_ZERO != 0) && (e_src2 == '0)) ? '0 : regs[e_src2];
    assign op_a = (wb_en && (w_dst == e_src1)) ? wb_val : rf_a;
    assign op_b = (wb_en && (w_dst == e_src2)) ? wb_val : rf_b;
    assign alu  = e_op ? (op_a - op_b + imm_ext) : (op_a + op_b + imm_ext);

    assign taken = e_valid & e_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            retired_q <= '0;
            d_valid   <= 1'b0;
            d_insn    <= '0;
            d_pc      <= '0;
            e_valid   <= 1'b0;
            e_insn    <= '0;
            e_pc      <= '0;
            w_valid   <= 1'b0;
            w_alu     <= '0;
            w_store   <= '0;
            w_dst     <= '0;
            w_mw      <= 1'b0;
            w_rw      <= 1'b0;
            w_rsrc    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (!stall) begin
            // A taken branch kills both the instruction in D and the one
            // being fetched this cycle; both are on the fall-through path.
            pc      <= taken ? (e_pc + alu) : (pc + XLEN'(1));
            d_valid <= !taken;
            d_insn  <= bus.insn[IW-1:0];
            d_pc    <= pc;

            e_valid <= d_valid & !taken;
            e_insn  <= d_insn;
            e_pc    <= d_pc;

            w_valid <= e_valid;
            w_alu   <= alu;
            w_store <= op_b;
            w_dst   <= e_dst;
            w_mw    <= e_mw;
            w_rw    <= e_rw;
            w_rsrc  <= e_rsrc;

            if (w_valid) begin
                retired_q <= retired_q + 32'd1;
            end
            if (wb_en) begin
                regs[w_dst] <= wb_val;
            end
        end
    end

    // All memory outputs come from W registers: no path from insn.
    assign bus.insn_addr = pc;
    assign bus.data_addr = w_alu;
    assign bus.data_out  = w_store;
    assign bus.data_w    = w_valid & w_mw;
    assign bus.retired   = retired_q;

    // Instruction bits above the defined fields are deliberately ignored.
    if (IW < 32) begin : g_insn_hi
        logic unused_insn_hi;
        assign unused_insn_hi = ^bus.insn[31:IW];
    end
endmodule

// File: tb/tb_processor_pipe3.sv
// tb_processor_pipe3: directed self-checking bench for processor_pipe3.
// A small ROM array feeds insn combinationally; a 16-word memory model
// answers loads and captures stores. Inputs change and outputs are sampled
// on the falling edge; k counts rising edges since reset was released.
module tb_processor_pipe3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_ready = 1'b1;
    logic ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [31:0] rom [16];
    logic [31:0] mem [16];
    int n_checks = 0;
    int n_fail = 0;

    processor_pipe3_if #(.XLEN(32)) bus_if ();

    processor_pipe3 #(.XLEN(32), .RA(5), .IMM_W(5), .R0_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Environment models
    assign bus_if.insn      = (bus_if.insn_addr < 32'd16) ? rom[bus_if.insn_addr[3:0]] : 32'h0;
    assign bus_if.data_in   = ovr_en ? ovr_val : mem[bus_if.data_addr[3:0]];
    assign bus_if.mem_ready = mem_ready;

    always @(posedge clk) begin
        if (!rst && bus_if.data_w && bus_if.mem_ready) begin
            mem[bus_if.data_addr[3:0]] <= bus_if.data_out;
        end
    end

    // Encoder for the default field layout
    function automatic logic [31:0] enc(input int s1, input int s2, input int dst,
                                        input int imm, input bit mw, input bit rw,
                                        input bit op, input bit rsrc, input bit b);
        logic [31:0] w;
        logic [31:0] t1, t2, t3, t4;
        w  = '0;
        t1 = s1;
        t2 = s2;
        t3 = dst;
        t4 = imm;
        w[4:0]   = t1[4:0];
        w[9:5]   = t2[4:0];
        w[14:10] = t3[4:0];
        w[19:15] = t4[4:0];
        w[20] = mw;
        w[21] = rw;
        w[22] = op;
        w[23] = rsrc;
        w[24] = b;
        return w;
    endfunction

    // Driver tasks
    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        ovr_en = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        // ---- Test 1: straight-line ALU with back-to-back dependency ----
        clear_rom();
        rom[0] = enc(0, 0, 1, 3, 0, 1, 0, 0, 0);  // R1 = 3
        rom[1] = enc(1, 1, 2, 0, 0, 1, 0, 0, 0);  // R2 = R1+R1 = 6
        rom[2] = enc(2, 2, 0, 8, 1, 0, 1, 0, 0);  // mem[8] = R2
        do_reset();
        check("rst_insn_addr", bus_if.insn_addr, 32'd0);     // k=0
        check("rst_retired", bus_if.retired, 32'd0);
        check("rst_data_w", {31'd0, bus_if.data_w}, 32'd0);
        check("rst_data_addr", bus_if.data_addr, 32'd0);
        check("rst_data_out", bus_if.data_out, 32'd0);
        tick(1);
        check("t1_pc1", bus_if.insn_addr, 32'd1);
        tick(1);
        check("t1_pc2", bus_if.insn_addr, 32'd2);
        tick(1);
        check("t1_pc3", bus_if.insn_addr, 32'd3);
        tick(1);
        check("t1_ret_k4", bus_if.retired, 32'd1);
        tick(1);
        check("t1_ret_k5", bus_if.retired, 32'd2);
        check("t1_st_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t1_st_addr", bus_if.data_addr, 32'd8);
        check("t1_r2_val", bus_if.data_out, 32'd6);
        tick(1);
        check("t1_st_once", {31'd0, bus_if.data_w}, 32'd0);

        // ---- Test 2: store/load round trip, load-use bypass ----
        clear_rom();
        rom[0] = enc(0, 0, 1, 5, 0, 1, 0, 0, 0);  // R1 = 5
        rom[1] = enc(1, 1, 0, 4, 1, 0, 1, 0, 0);  // mem[4] = R1
        rom[2] = enc(0, 0, 3, 4, 0, 1, 0, 1, 0);  // R3 = mem[4]
        rom[3] = enc(3, 3, 0, 2, 1, 0, 1, 0, 0);  // mem[2] = R3
        do_reset();
        tick(3);
        check("t2_pre_w", {31'd0, bus_if.data_w}, 32'd0);
        tick(1);
        check("t2_st_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t2_st_addr", bus_if.data_addr, 32'd4);
        check("t2_st_data", bus_if.data_out, 32'd5);
        tick(1);
        check("t2_ld_nowrite", {31'd0, bus_if.data_w}, 32'd0);
        check("t2_ld_addr", bus_if.data_addr, 32'd4);
        tick(1);
        check("t2_st3_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t2_st3_addr", bus_if.data_addr, 32'd2);
        check("t2_r3_val", bus_if.data_out, 32'd5);

        // ---- Test 3: load stalled three cycles ----
        clear_rom();
        rom[0] = enc(0, 0, 4, 1, 0, 1, 0, 1, 0);  // R4 = mem[1]
        rom[2] = enc(4, 4, 0, 3, 1, 0, 1, 0, 0);  // mem[3] = R4
        do_reset();
        tick(2);
        mem_ready = 1'b0;
        ovr_en = 1'b1;
        ovr_val = 32'h5A;
        tick(1);
        check("t3_pc_k3", bus_if.insn_addr, 32'd3);
        check("t3_addr_k3", bus_if.data_addr, 32'd1);
        check("t3_ret_k3", bus_if.retired, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check("t3_pc_frozen", bus_if.insn_addr, 32'd3);
            check("t3_ret_frozen", bus_if.retired, 32'd0);
            check("t3_addr_frozen", bus_if.data_addr, 32'd1);
        end
        mem_ready = 1'b1;
        ovr_val = 32'hA5;
        tick(1);
        check("t3_ret_release", bus_if.retired, 32'd1);
        check("t3_pc_release", bus_if.insn_addr, 32'd4);
        tick(1);
        check("t3_st_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t3_st_addr", bus_if.data_addr, 32'd3);
        check("t3_r4_val", bus_if.data_out, 32'hA5);
        ovr_en = 1'b0;

        // ---- Test 4: taken branch with squash ----
        clear_rom();
        rom[0] = enc(0, 0, 1, 1, 0, 1, 0, 0, 0);   // R1 = 1
        rom[1] = enc(5, 5, 0, 0, 1, 0, 1, 0, 0);   // mem[0] = R5
        rom[2] = enc(0, 0, 0, -2, 0, 0, 0, 0, 1);  // branch to pc-2
        rom[3] = enc(0, 0, 5, 7, 0, 1, 0, 0, 0);   // R5 = 7 (wrong path)
        rom[4] = enc(0, 0, 5, 9, 0, 1, 0, 0, 0);   // R5 = 9 (wrong path)
        do_reset();
        tick(4);
        check("t4_pc_k4", bus_if.insn_addr, 32'd4);
        check("t4_r5_first", bus_if.data_out, 32'd0);
        tick(1);
        check("t4_target", bus_if.insn_addr, 32'd0);
        tick(1);
        check("t4_pc_after", bus_if.insn_addr, 32'd1);
        check("t4_ret_br", bus_if.retired, 32'd3);
        tick(1);
        check("t4_ret_squash", bus_if.retired, 32'd3);
        tick(2);
        check("t4_ret_again", bus_if.retired, 32'd4);
        check("t4_st2_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t4_r5_second", bus_if.data_out, 32'd0);

        // ---- Test 5: R0 hardwired to zero ----
        clear_rom();
        rom[0] = enc(0, 0, 0, 7, 0, 1, 0, 0, 0);  // R0 = 7 (dropped)
        rom[1] = enc(0, 0, 1, 0, 0, 1, 0, 0, 0);  // R1 = R0+R0
        rom[2] = enc(1, 1, 0, 0, 1, 0, 1, 0, 0);  // mem[0] = R1
        rom[3] = enc(0, 0, 0, 6, 1, 0, 1, 0, 0);  // mem[6] = R0
        do_reset();
        tick(5);
        check("t5_st_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t5_r1_val", bus_if.data_out, 32'd0);
        tick(1);
        check("t5_r0_addr", bus_if.data_addr, 32'd6);
        check("t5_r0_val", bus_if.data_out, 32'd0);

        // ---- Test 6: reset during a stalled store ----
        clear_rom();
        rom[0] = enc(0, 0, 0, 3, 1, 0, 0, 0, 0);  // mem[3] = R0
        do_reset();
        tick(2);
        mem_ready = 1'b0;
        tick(1);
        check("t6_st_w", {31'd0, bus_if.data_w}, 32'd1);
        check("t6_st_addr", bus_if.data_addr, 32'd3);
        tick(1);
        check("t6_st_held", {31'd0, bus_if.data_w}, 32'd1);
        check("t6_pc_held", bus_if.insn_addr, 32'd3);
        rst = 1'b1;
        tick(1);
        check("t6_rst_w", {31'd0, bus_if.data_w}, 32'd0);
        check("t6_rst_pc", bus_if.insn_addr, 32'd0);
        check("t6_rst_ret", bus_if.retired, 32'd0);
        check("t6_rst_addr", bus_if.data_addr, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        tick(2);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/processor_pipe3.md
Name: processor_pipe3

Overview:
- Parametrised three-stage successor of the two-stage core: Decode (D), Execute (E), Memory/Writeback (W).
- Same instruction fields and flag semantics as the two-stage core.
- Adds synchronous reset, W→E operand bypass, taken-branch squash, a data-memory ready stall, optional hardwired-zero R0 and a retired-instruction counter.
- Sits between the instruction ROM and the data memory; the register file is internal.

Parameters:
- XLEN, 32, datapath / PC / register width.
- RA, 5, register address width; NREGS = 2**RA.
- IMM_W, 5, immediate width, sign-extended to XLEN.
- R0_ZERO, 1, 1: R0 reads 0 and writes to it are dropped.
- Constraint: 3*RA+IMM_W+5 <= 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- insn  in  32  instruction at insn_addr (combinational ROM).
- insn_addr  out  XLEN  current PC.
- data_w  out  1  data memory write strobe.
- data_out  out  XLEN  store data.
- data_in  in  XLEN  load data, valid when mem_ready=1.
- data_addr  out  XLEN  data memory address.
- mem_ready  in  1  data memory completes access this cycle.
- retired  out  32  instructions retired from W, wraps.

Behaviour:
- Encoding, LSB up:
  - src1 [RA-1:0], src2 next RA, dst next RA, imm next IMM_W.
  - Then m_w, r_w, op, r_src, b at bits F..F+4, where F = 3*RA+IMM_W.
  - Remaining upper bits are ignored.
  - Defaults: src1[4:0] src2[9:5] dst[14:10] imm[19:15] m_w[20] r_w[21] op[22] r_src[23] b[24].
- ALU, XLEN-wide, modulo 2^XLEN:
  - op=0: A+B+sext(imm).
  - op=1: A-B+sext(imm).
- Each stage holds a valid bit; an invalid stage has all side effects suppressed.
- Per cycle, when not stalled:
  - D latches insn, its PC, and valid=1.
  - E receives D.
  - W receives E's alu result, store data and control.
- Register file:
  - Read in E.
  - Written at the rising edge ending W when W.valid & r_w.
  - Write value = r_src ? data_in : alu_result.
- Bypass: if W.valid & W.r_w & W.dst==E.srcN (and not R0 when R0_ZERO), E operand N takes the W writeback value. Applies to src1 (A), src2 (B) and src2 as store data.
- Branch:
  - Resolved in E when E.valid & E.b.
  - Next PC = E.pc + alu_result; the D instruction is squashed (valid=0).
  - A branch still flows to W and may also write a register if r_w=1.
  - Otherwise PC = PC+1.
- Memory outputs:
  - data_addr = W.alu_result.
  - data_out = W.store_data.
  - data_w = W.valid & W.m_w.
  - All outputs are registered-stage driven, with no combinational path from insn.
- Stall:
  - Condition: W.valid & (m_w | r_src) & !mem_ready.
  - PC, D, E and W all hold; no register write; retired holds; data_w stays asserted.
  - Releases on the cycle mem_ready=1.
- retired increments by 1 per cycle in which W.valid and not stalled.
- Reset, synchronous, wins over stall:
  - pc=0; all valid=0; all registers=0; retired=0.
  - Outputs: insn_addr=0, data_w=0, data_addr=0, data_out=0.
  - Reset asserted mid-access abandons the access.
- First instruction retires 3 cycles after rst deasserts.
- Back-to-back dependent ALU ops run without a bubble.
- Load-use at distance 1 (load in W, user in E) uses the bypass with data_in.
- Writes to R0 with R0_ZERO=1: no register update; bypass also disabled.
- PC wraps modulo 2^XLEN.

Test Plan:
- Reset then straight-line ALU:
  - R1=R0+R0+imm 3, then R2=R1+R1+imm 0.
  - Expect R2=6 with no stall; insn_addr sequence 0,1,2,3; retired=2 two cycles after the second instruction reaches E.
- Store/load round trip:
  - R1=5; store R1 at addr R0+imm 4; load into R3 from addr 4, with mem_ready=1.
  - Expect data_w=1, data_addr=4, data_out=5 for exactly one cycle; R3=5.
- Memory stall:
  - Load with mem_ready held 0 for 3 cycles.
  - Expect insn_addr, retired and data_addr frozen for 3 cycles; write of data_in=0xA5 occurs on the cycle mem_ready rises.
- Taken branch:
  - Branch at pc=2 with op=0, src1=src2=R0, imm=-2.
  - Expect next insn_addr=0; the instruction at pc=3 squashed (no register write, retired unaffected by it).
- R0_ZERO:
  - Write R0=7, then R1=R0+R0.
  - Expect R1=0.
- Reset mid-stall:
  - rst=1 while a store stalls.
  - Next cycle data_w=0, insn_addr=0, retired=0.
